// File: rtl/ioq_header_inserter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ioq_header_inserter_pkg
// Purpose  : Shared IOQ module-header constants: the header ctrl code, the
//            bit positions of the header fields and the output FSM encodings.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ioq_header_inserter_pkg;

    // ctrl value that tags a word as the IOQ module header
    localparam logic [7:0] IO_QUEUE_STAGE_NUM = 8'hFF;

    // 16-bit field positions inside the header data word
    localparam int IOQ_BYTE_LEN_POS = 0;
    localparam int IOQ_SRC_PORT_POS = 16;
    localparam int IOQ_WORD_LEN_POS = 32;
    localparam int IOQ_DST_PORT_POS = 48;

    // One-hot output state machine encodings
    localparam int         OUT_STATE_W = 3;
    localparam logic [2:0] OUT_IDLE    = 3'b001;
    localparam logic [2:0] OUT_HDR     = 3'b010;
    localparam logic [2:0] OUT_DATA    = 3'b100;

endpackage : ioq_header_inserter_pkg
`default_nettype wire

// File: rtl/fallthrough_small_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fallthrough_small_fifo
// Purpose  : Synchronous FIFO whose head entry is visible on dout while the
//            FIFO is non-empty (no read latency). Push and pop in the same
//            cycle are both honoured.
// Ports    : clk, reset (sync, active-high), din/wr_en (push),
//            rd_en (pop), dout (head entry), full, empty
// Revision : 1.0 - initial release
// ============================================================================
module fallthrough_small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int c_depth = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS-1:0] c_ptr_one = 1;
    localparam logic [MAX_DEPTH_BITS:0]   c_cnt_one = 1;

    logic [WIDTH-1:0]          mem [c_depth];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [MAX_DEPTH_BITS:0]   count_q, count_d;
    logic                      w_push;
    logic                      w_pop;

    // count never exceeds the depth, so its MSB alone flags "full"
    assign full   = count_q[MAX_DEPTH_BITS];
    assign empty  = (count_q == '0);
    assign w_push = wr_en && !full;
    assign w_pop  = rd_en && !empty;
    assign dout   = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) wr_ptr_d = wr_ptr_q + c_ptr_one;
        if (w_pop)  rd_ptr_d = rd_ptr_q + c_ptr_one;
        if (w_push && !w_pop)      count_d = count_q + c_cnt_one;
        else if (w_pop && !w_push) count_d = count_q - c_cnt_one;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage is not reset; empty gates every use of dout
    always_ff @(posedge clk) begin
        if (w_push) mem[wr_ptr_q] <= din;
    end

endmodule : fallthrough_small_fifo
`default_nettype wire

// File: rtl/ioq_header_inserter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ioq_header_inserter
// Purpose  : Buffers each packet while counting its words and bytes, then
//            emits an IOQ module header (one-hot dst port, word length, byte
//            length) followed by the unchanged packet words.
// Ports    : clk, reset (sync, active-high)
//            in_data/in_ctrl/in_wr/in_rdy - input word stream, dst_oq index
//            out_data/out_ctrl/out_wr     - registered output stream
//            out_rdy                      - downstream accepts a word next cycle
// Revision : 1.0 - initial release
// ============================================================================
module ioq_header_inserter
    import ioq_header_inserter_pkg::*;
#(
    parameter int                    DATA_WIDTH           = 64,
    parameter int                    CTRL_WIDTH           = DATA_WIDTH / 8,
    parameter logic [CTRL_WIDTH-1:0] IOQ_STAGE_NUM        = CTRL_WIDTH'(IO_QUEUE_STAGE_NUM),
    parameter int                    NUM_OUTPUT_QUEUES    = 8,
    parameter int                    NUM_OQ_WIDTH         = $clog2(NUM_OUTPUT_QUEUES),
    parameter int                    MAX_PKT              = 2048,
    parameter int                    BYTE_CNT_WIDTH       = $clog2(MAX_PKT) + 1,
    parameter int                    WORD_CNT_WIDTH       = $clog2(MAX_PKT / CTRL_WIDTH) + 1,
    parameter int                    DATA_FIFO_DEPTH_BITS = 9,
    parameter int                    META_FIFO_DEPTH_BITS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [CTRL_WIDTH-1:0]   in_ctrl,
    input  logic                    in_wr,
    output logic                    in_rdy,
    input  logic [NUM_OQ_WIDTH-1:0] dst_oq,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [CTRL_WIDTH-1:0]   out_ctrl,
    output logic                    out_wr,
    input  logic                    out_rdy
);

    localparam int c_dfifo_width = CTRL_WIDTH + DATA_WIDTH;
    localparam int c_meta_width  = WORD_CNT_WIDTH + BYTE_CNT_WIDTH + NUM_OQ_WIDTH;
    localparam int c_byte_shift  = $clog2(CTRL_WIDTH);
    localparam logic [WORD_CNT_WIDTH-1:0] c_word_one = 1;

    // ---------------- input side ----------------
    logic                      sop_q, sop_d;
    logic [NUM_OQ_WIDTH-1:0]   dst_q, dst_d;
    logic [WORD_CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;

    logic                      w_in_accept;
    logic                      w_in_eop;
    logic [NUM_OQ_WIDTH-1:0]   w_pkt_dst;
    logic [WORD_CNT_WIDTH-1:0] w_word_cnt_inc;
    logic [BYTE_CNT_WIDTH-1:0] w_eop_bytes;
    logic [BYTE_CNT_WIDTH-1:0] w_byte_cnt;

    logic                      w_data_full, w_data_empty, w_data_rd;
    logic [c_dfifo_width-1:0]  w_data_dout;
    logic                      w_meta_full, w_meta_empty, w_meta_rd;
    logic [c_meta_width-1:0]   w_meta_dout;

    assign in_rdy      = !w_data_full && !w_meta_full;
    assign w_in_accept = in_wr && in_rdy;
    assign w_in_eop    = w_in_accept && (in_ctrl != '0);

    // a single-word packet must use dst_oq straight from the port
    assign w_pkt_dst      = sop_q ? dst_oq : dst_q;
    assign w_word_cnt_inc = word_cnt_q + c_word_one;

    // Valid bytes in the EOP word: ctrl bit k set means CTRL_WIDTH-k bytes
    always_comb begin
        w_eop_bytes = '0;
        for (int i = 0; i < CTRL_WIDTH; i++) begin
            if (in_ctrl[i]) w_eop_bytes = BYTE_CNT_WIDTH'(CTRL_WIDTH - i);
        end
    end

    // word_cnt_q still excludes the EOP word, so it counts the full words
    assign w_byte_cnt = (BYTE_CNT_WIDTH'(word_cnt_q) << c_byte_shift) + w_eop_bytes;

    always_comb begin
        sop_d      = sop_q;
        dst_d      = dst_q;
        word_cnt_d = word_cnt_q;
        if (w_in_accept) begin
            if (sop_q) dst_d = dst_oq;
            if (w_in_eop) begin
                word_cnt_d = '0;
                sop_d      = 1'b1;
            end else begin
                word_cnt_d = w_word_cnt_inc;
                sop_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sop_q      <= 1'b1;
            dst_q      <= '0;
            word_cnt_q <= '0;
        end else begin
            sop_q      <= sop_d;
            dst_q      <= dst_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    fallthrough_small_fifo #(
        .WIDTH          (c_dfifo_width),
        .MAX_DEPTH_BITS (DATA_FIFO_DEPTH_BITS)
    ) u_data_fifo (
        .clk   (clk),
        .reset (reset),
        .din   ({in_ctrl, in_data}),
        .wr_en (w_in_accept),
        .rd_en (w_data_rd),
        .dout  (w_data_dout),
        .full  (w_data_full),
        .empty (w_data_empty)
    );

    fallthrough_small_fifo #(
        .WIDTH          (c_meta_width),
        .MAX_DEPTH_BITS (META_FIFO_DEPTH_BITS)
    ) u_meta_fifo (
        .clk   (clk),
        .reset (reset),
        .din   ({w_word_cnt_inc, w_byte_cnt, w_pkt_dst}),
        .wr_en (w_in_eop),
        .rd_en (w_meta_rd),
        .dout  (w_meta_dout),
        .full  (w_meta_full),
        .empty (w_meta_empty)
    );

    // ---------------- output side ----------------
    logic [WORD_CNT_WIDTH-1:0] w_meta_words;
    logic [BYTE_CNT_WIDTH-1:0] w_meta_bytes;
    logic [NUM_OQ_WIDTH-1:0]   w_meta_dst;
    logic [DATA_WIDTH-1:0]     w_hdr;

    assign {w_meta_words, w_meta_bytes, w_meta_dst} = w_meta_dout;

    always_comb begin
        w_hdr = '0;
        w_hdr[IOQ_DST_PORT_POS +: 16] = 16'd1 << w_meta_dst;
        w_hdr[IOQ_WORD_LEN_POS +: 16] = 16'(w_meta_words);
        w_hdr[IOQ_SRC_PORT_POS +: 16] = 16'd0;
        w_hdr[IOQ_BYTE_LEN_POS +: 16] = 16'(w_meta_bytes);
    end

    logic [OUT_STATE_W-1:0] state_q, state_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic [CTRL_WIDTH-1:0]  out_ctrl_q, out_ctrl_d;
    logic                   out_wr_q, out_wr_d;

    // The meta entry stays at the FIFO head for the whole packet and is
    // popped together with the EOP word, so the header reads it in place.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_ctrl_d = out_ctrl_q;
        out_wr_d   = 1'b0;
        w_data_rd  = 1'b0;
        w_meta_rd  = 1'b0;
        case (state_q)
            OUT_IDLE: begin
                if (!w_meta_empty) state_d = OUT_HDR;
            end
            OUT_HDR: begin
                if (out_rdy) begin
                    out_wr_d   = 1'b1;
                    out_data_d = w_hdr;
                    out_ctrl_d = IOQ_STAGE_NUM;
                    state_d    = OUT_DATA;
                end
            end
            OUT_DATA: begin
                if (out_rdy && !w_data_empty) begin
                    w_data_rd  = 1'b1;
                    out_wr_d   = 1'b1;
                    out_data_d = w_data_dout[DATA_WIDTH-1:0];
                    out_ctrl_d = w_data_dout[DATA_WIDTH +: CTRL_WIDTH];
                    if (w_data_dout[DATA_WIDTH +: CTRL_WIDTH] != '0) begin
                        w_meta_rd = 1'b1;
                        state_d   = OUT_IDLE;
                    end
                end
            end
            default: state_d = OUT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= OUT_IDLE;
            out_data_q <= '0;
            out_ctrl_q <= '0;
            out_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_ctrl_q <= out_ctrl_d;
            out_wr_q   <= out_wr_d;
        end
    end

    assign out_data = out_data_q;
    assign out_ctrl = out_ctrl_q;
    assign out_wr   = out_wr_q;

`ifndef SYNTHESIS
    // Unsupported input traffic stops simulation immediately
    always_ff @(posedge clk) begin
        if (!reset && in_wr) begin
            assert (in_rdy)
                else $fatal(1, "ioq_header_inserter: in_wr while in_rdy is low");
            assert (word_cnt_q < WORD_CNT_WIDTH'(MAX_PKT / CTRL_WIDTH))
                else $fatal(1, "ioq_header_inserter: packet longer than MAX_PKT");
            assert ((in_ctrl == '0) || $onehot(in_ctrl))
                else $fatal(1, "ioq_header_inserter: EOP ctrl has more than one bit set");
        end
    end
`endif

endmodule : ioq_header_inserter
`default_nettype wire

// File: tb/tb_ioq_header_inserter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ioq_header_inserter
// Purpose  : Directed scoreboard bench for ioq_header_inserter. Stimulus
//            pushes the expected header and packet words into a queue; an
//            independent monitor pops and compares every out_wr word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ioq_header_inserter;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [2:0]  dst_oq;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;

    logic        rdy_base;
    logic        toggle_en;
    logic        tog_q;

    assign out_rdy = toggle_en ? tog_q : rdy_base;

    always #5 clk = ~clk;

    always @(negedge clk) tog_q <= toggle_en ? ~tog_q : 1'b1;

    ioq_header_inserter dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .in_wr    (in_wr),
        .in_rdy   (in_rdy),
        .dst_oq   (dst_oq),
        .out_data (out_data),
        .out_ctrl (out_ctrl),
        .out_wr   (out_wr),
        .out_rdy  (out_rdy)
    );

    int          n_checks;
    int          n_pass;
    logic [71:0] exp_q[$];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic rdy_prev;
    logic check_bubble;
    logic bubble_armed;
    int   gap;

    always @(posedge clk) rdy_prev <= out_rdy;

    initial begin
        gap          = 0;
        bubble_armed = 1'b0;
        forever begin
            @(negedge clk);
            if (out_wr === 1'b1) begin
                check("out_wr_after_rdy", {71'd0, rdy_prev}, 72'd1);
                if (out_ctrl == 8'hFF && check_bubble && bubble_armed)
                    check("idle_bubble", 72'(gap), 72'd1);
                if (out_ctrl != 8'h00 && out_ctrl != 8'hFF) begin
                    bubble_armed = check_bubble;
                    gap          = 0;
                end
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got %h, expected no output", {out_ctrl, out_data});
                end else begin
                    check("scoreboard", {out_ctrl, out_data}, exp_q.pop_front());
                end
            end else begin
                gap++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic finish_now();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "bench stopped early");
    endtask

    task automatic drive_word(input logic [63:0] d, input logic [7:0] c, input logic [2:0] dst);
        int guard;
        guard = 0;
        @(negedge clk);
        while (in_rdy !== 1'b1 && guard < 1000) begin
            in_wr = 1'b0;
            @(negedge clk);
            guard++;
        end
        if (in_rdy !== 1'b1) begin
            n_checks++;
            $display("FAIL in_rdy_timeout: got in_rdy=%b, expected 1 within 1000 cycles", in_rdy);
            finish_now();
        end
        in_data = d;
        in_ctrl = c;
        dst_oq  = dst;
        in_wr   = 1'b1;
    endtask

    // dst_oq is scrambled on non-first words to prove it is sampled at SOP only
    task automatic send_pkt(input int n, input logic [7:0] eop, input logic [2:0] dst,
                            input logic [63:0] hdr, input int seed, input bit expect_it);
        logic [63:0] d;
        logic [7:0]  c;
        if (expect_it) exp_q.push_back({8'hFF, hdr});
        for (int i = 0; i < n; i++) begin
            d = {seed[15:0], 16'hD47A, 32'(i) ^ 32'h5A5A_0000};
            c = (i == n - 1) ? eop : 8'h00;
            if (expect_it) exp_q.push_back({c, d});
            drive_word(d, c, (i == 0) ? dst : ~dst);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_wr = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        check(name, 72'(exp_q.size()), 72'd0);
        repeat (4) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b1;
        in_wr        = 1'b0;
        in_data      = '0;
        in_ctrl      = '0;
        dst_oq       = '0;
        rdy_base     = 1'b0;
        toggle_en    = 1'b0;
        check_bubble = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_out_wr",   {71'd0, out_wr}, 72'd0);
        check("reset_out_data", {8'd0, out_data}, 72'd0);
        check("reset_out_ctrl", {64'd0, out_ctrl}, 72'd0);
        reset = 1'b0;
        @(negedge clk);
        check("reset_in_rdy", {71'd0, in_rdy}, 72'd1);

        // 1-word packet, dst 2, 8 bytes; header must appear 3 cycles after EOP
        rdy_base = 1'b1;
        send_pkt(1, 8'h01, 3'd2, 64'h0004_0001_0000_0008, 1, 1'b1);
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            in_wr = 1'b0;
            if (out_wr === 1'b1) lat = k;
        end
        check("hdr_latency", 72'(lat), 72'd3);
        wait_drain("drain_1word");

        // 3-word packet, EOP ctrl 0x20 -> 3 valid bytes -> 19 bytes, dst 7
        send_pkt(3, 8'h20, 3'd7, 64'h0080_0003_0000_0013, 2, 1'b1);
        idle();
        wait_drain("drain_3word");

        // Stall output while 4 packets fill the meta FIFO
        rdy_base = 1'b0;
        send_pkt(2, 8'h80, 3'd0, 64'h0001_0002_0000_0009, 3, 1'b1);
        send_pkt(1, 8'h04, 3'd5, 64'h0020_0001_0000_0006, 4, 1'b1);
        send_pkt(4, 8'h02, 3'd3, 64'h0008_0004_0000_001F, 5, 1'b1);
        send_pkt(3, 8'h10, 3'd1, 64'h0002_0003_0000_0014, 6, 1'b1);
        idle();
        check("in_rdy_meta_full", {71'd0, in_rdy}, 72'd0);
        check("no_out_while_stalled", {71'd0, out_wr}, 72'd0);
        check_bubble = 1'b1;
        rdy_base     = 1'b1;
        wait_drain("drain_stalled4");
        check_bubble = 1'b0;

        // Maximum packet: 256 words, 2048 bytes, dst 4
        send_pkt(256, 8'h01, 3'd4, 64'h0010_0100_0000_0800, 7, 1'b1);
        idle();
        wait_drain("drain_maxpkt");

        // out_rdy toggling every cycle, two back-to-back packets
        toggle_en = 1'b1;
        send_pkt(3, 8'h08, 3'd6, 64'h0040_0003_0000_0015, 8, 1'b1);
        send_pkt(2, 8'h40, 3'd2, 64'h0004_0002_0000_000A, 9, 1'b1);
        idle();
        wait_drain("drain_toggle");
        toggle_en = 1'b0;

        // Reset mid-packet: a buffered packet and a partial one are discarded
        rdy_base = 1'b0;
        send_pkt(3, 8'h01, 3'd5, 64'h0, 10, 1'b0);
        for (int i = 0; i < 4; i++) drive_word(64'hBAD0_0000_0000_0000 | 64'(i), 8'h00, 3'd3);
        drive_word(64'hBAD0_0000_0000_0004, 8'h00, 3'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        in_wr = 1'b0;
        check("midreset_out_wr",   {71'd0, out_wr}, 72'd0);
        check("midreset_out_ctrl", {64'd0, out_ctrl}, 72'd0);
        @(negedge clk);
        check("midreset_in_rdy", {71'd0, in_rdy}, 72'd1);
        rdy_base = 1'b1;
        send_pkt(2, 8'h01, 3'd6, 64'h0040_0002_0000_0010, 11, 1'b1);
        idle();
        wait_drain("drain_after_reset");
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        n_checks++;
        $display("FAIL global_timeout: got still running, expected completion");
        finish_now();
    end

endmodule : tb_ioq_header_inserter
`default_nettype wire
